// File: rtl/sg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sg_pkg
// Brief    : Shared types and constants for the signal-generator sequencer:
//            FSM state encoding, host programming field codes and the
//            generator register-port widths.
// Revision : 1.0 - initial release
// ============================================================================
package sg_pkg;

  // Generator register port geometry; a table reg word is {addr, data}.
  localparam int SG_ADDR_W = 3;
  localparam int SG_DATA_W = 5;
  localparam int SG_REG_W  = SG_ADDR_W + SG_DATA_W;

  // Host programming field selector codes.
  localparam logic [1:0] FLD_REG = 2'd0;
  localparam logic [1:0] FLD_DUR = 2'd1;
  localparam logic [1:0] FLD_LEN = 2'd2;
  localparam logic [1:0] FLD_RSV = 2'd3;

  // Playback FSM states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_WAIT   = 3'd4
  } sg_state_t;

endpackage : sg_pkg
`default_nettype wire

// File: rtl/sg_seq_table.sv
`default_nettype none
// ============================================================================
// Module   : sg_seq_table
// Brief    : Sequencer program storage: DEPTH entries of {reg word, dwell}
//            plus the sequence length register, with one asynchronous read
//            port. Length writes are clamped to DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module sg_seq_table
  import sg_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DUR_W = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [1:0]          field_i,
  input  logic [IW-1:0]       idx_i,
  input  logic [7:0]          data_i,
  input  logic [IW-1:0]       rd_idx_i,
  output logic [SG_REG_W-1:0] rd_reg_o,
  output logic [DUR_W-1:0]    rd_dur_o,
  output logic [IW:0]         seq_len_o
);

  localparam int LW = IW + 1;

  logic [SG_REG_W-1:0] reg_q [DEPTH];
  logic [DUR_W-1:0]    dur_q [DEPTH];
  logic [LW-1:0]       seq_len_q;

  logic [DUR_W-1:0]    w_dur_wr;
  logic [LW-1:0]       w_len_wr;

  // Fit the 8-bit host value to the dwell counter width.
  if (DUR_W > 8) begin : g_dur_wide
    assign w_dur_wr = {{(DUR_W-8){1'b0}}, data_i};
  end else if (DUR_W == 8) begin : g_dur_exact
    assign w_dur_wr = data_i;
  end else begin : g_dur_narrow
    assign w_dur_wr = data_i[DUR_W-1:0];
  end

  // A length beyond the table size would never reach its last entry.
  assign w_len_wr = (int'(data_i) > DEPTH) ? LW'(DEPTH) : LW'(data_i);

  // Entry storage and length register; the reserved field code falls through.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i] <= '0;
        dur_q[i] <= '0;
      end
      seq_len_q <= '0;
    end else if (we_i) begin
      case (field_i)
        FLD_REG: reg_q[idx_i] <= data_i;
        FLD_DUR: dur_q[idx_i] <= w_dur_wr;
        FLD_LEN: seq_len_q    <= w_len_wr;
        default: ;
      endcase
    end
  end

  assign rd_reg_o  = reg_q[rd_idx_i];
  assign rd_dur_o  = dur_q[rd_idx_i];
  assign seq_len_o = seq_len_q;

endmodule : sg_seq_table
`default_nettype wire

// File: rtl/sg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sg_sequencer
// Brief    : Autonomous register-write sequencer. Plays a host-programmed
//            table of generator writes, each followed by a tick-counted
//            dwell, into the generator write port with setup/strobe/hold
//            framing. Supports looping and clean abort.
// Revision : 1.0 - initial release
// ============================================================================
module sg_sequencer
  import sg_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int DUR_W      = 8,
  parameter  int STROBE_CYC = 2,
  localparam int IW         = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 prog_we,
  input  logic [1:0]           prog_field,
  input  logic [IW-1:0]        prog_idx,
  input  logic [7:0]           prog_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop_en,
  output logic                 sg_strobe,
  output logic [SG_ADDR_W-1:0] sg_addr,
  output logic [SG_DATA_W-1:0] sg_data,
  output logic                 busy,
  output logic [IW-1:0]        step_idx,
  output logic                 done,
  output logic                 prog_err
);

  localparam int LW  = IW + 1;
  localparam int SCW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  // State and registered outputs
  sg_state_t            state_q,     state_d;
  logic [IW-1:0]        step_idx_q,  step_idx_d;
  logic [SG_ADDR_W-1:0] addr_q,      addr_d;
  logic [SG_DATA_W-1:0] data_q,      data_d;
  logic [DUR_W-1:0]     dur_cur_q,   dur_cur_d;
  logic [DUR_W-1:0]     dwell_q,     dwell_d;
  logic [SCW-1:0]       strb_cnt_q,  strb_cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 strobe_q,    strobe_d;
  logic                 busy_q,      busy_d;
  logic                 done_q,      done_d;
  logic                 prog_err_q,  prog_err_d;

  // Table interface and control helpers
  logic                 w_tbl_we;
  logic [IW-1:0]        w_rd_idx;
  logic [SG_REG_W-1:0]  w_rd_reg;
  logic [DUR_W-1:0]     w_rd_dur;
  logic [LW-1:0]        w_seq_len;
  logic                 w_last;
  logic [IW-1:0]        w_nxt_idx;
  logic                 w_load;
  logic                 w_advance;

  // The table is only writable while idle so a playing entry never changes.
  assign w_tbl_we = prog_we && (state_q == S_IDLE);

  sg_seq_table #(
    .DEPTH (DEPTH),
    .DUR_W (DUR_W),
    .IW    (IW)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .we_i      (w_tbl_we),
    .field_i   (prog_field),
    .idx_i     (prog_idx),
    .data_i    (prog_data),
    .rd_idx_i  (w_rd_idx),
    .rd_reg_o  (w_rd_reg),
    .rd_dur_o  (w_rd_dur),
    .seq_len_o (w_seq_len)
  );

  // The next entry index depends only on registered state, so the read port
  // can present the entry to be loaded without a combinational loop.
  assign w_last    = ({1'b0, step_idx_q} == (w_seq_len - LW'(1)));
  assign w_nxt_idx = w_last ? '0 : step_idx_q + IW'(1);
  assign w_rd_idx  = (state_q == S_IDLE) ? '0 : w_nxt_idx;

  // Next-state, dwell/strobe counting and output-register next values.
  always_comb begin
    state_d     = state_q;
    step_idx_d  = step_idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    dur_cur_d   = dur_cur_q;
    dwell_d     = dwell_q;
    strb_cnt_d  = strb_cnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    w_load      = 1'b0;
    w_advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop && (w_seq_len != '0)) begin
          state_d    = S_SETUP;
          step_idx_d = '0;
          w_load     = 1'b1;
        end
      end
      S_SETUP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_STROBE;
          strb_cnt_d = '0;
        end
      end
      S_STROBE: begin
        // A stop here must not truncate the generator write.
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (strb_cnt_q == SCW'(STROBE_CYC - 1)) begin
          state_d = S_HOLD;
        end else begin
          strb_cnt_d = strb_cnt_q + SCW'(1);
        end
      end
      S_HOLD: begin
        if (stop || stop_pend_q) begin
          state_d = S_IDLE;
        end else if (dur_cur_q == '0) begin
          w_advance = 1'b1;
        end else begin
          state_d = S_WAIT;
          dwell_d = '0;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (dwell_q == dur_cur_q) begin
          w_advance = 1'b1;
        end else if (tick) begin
          dwell_d = dwell_q + DUR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_advance) begin
      if (w_last && !loop_en) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d    = S_SETUP;
        step_idx_d = w_nxt_idx;
        w_load     = 1'b1;
      end
    end

    // Entering SETUP: latch the entry so addr/data are valid in SETUP itself.
    if (w_load) begin
      addr_d    = w_rd_reg[SG_REG_W-1:SG_DATA_W];
      data_d    = w_rd_reg[SG_DATA_W-1:0];
      dur_cur_d = w_rd_dur;
    end
  end

  // Registered outputs track the state being entered.
  assign strobe_d   = (state_d == S_STROBE);
  assign busy_d     = (state_d != S_IDLE);
  assign prog_err_d = prog_we && (state_q != S_IDLE) && (prog_field != FLD_RSV);

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_idx_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      dur_cur_q   <= '0;
      dwell_q     <= '0;
      strb_cnt_q  <= '0;
      stop_pend_q <= 1'b0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_idx_q  <= step_idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dur_cur_q   <= dur_cur_d;
      dwell_q     <= dwell_d;
      strb_cnt_q  <= strb_cnt_d;
      stop_pend_q <= stop_pend_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      prog_err_q  <= prog_err_d;
    end
  end

  assign sg_strobe = strobe_q;
  assign sg_addr   = addr_q;
  assign sg_data   = data_q;
  assign busy      = busy_q;
  assign step_idx  = step_idx_q;
  assign done      = done_q;
  assign prog_err  = prog_err_q;

endmodule : sg_sequencer
`default_nettype wire

// File: doc/sg_sequencer.md
# sg_sequencer

Autonomous register-write sequencer for the `signal_generator`. It holds a small host-programmed table of register writes, each with a dwell time, and plays them back into the generator's write port. It drives the generator's `write_strobe`/`address`/`data` inputs in place of raw pins, so a melody or sweep runs without host involvement. It sits between the top-level pin decode and `signal_generator`, on the same clock as the generator.

## Interface
Parameters:
- `DEPTH`, 8: table entries; must be a power of 2; index width `IW = log2(DEPTH)`.
- `DUR_W`, 8: dwell-counter width, in ticks.
- `STROBE_CYC`, 2: cycles `sg_strobe` is held high per write; must be ≥1.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `tick`  in  1: dwell time base, a one-`clk` pulse (e.g. from `clock_scale`).
- `prog_we`  in  1: host table write, one-cycle pulse.
- `prog_field`  in  2: 0 = reg word `{addr[2:0],data[4:0]}`, 1 = duration, 2 = length, 3 = reserved (ignored).
- `prog_idx`  in  IW: entry index (ignored for field 2).
- `prog_data`  in  8: write value.
- `start`  in  1: begin playback.
- `stop`  in  1: abort playback.
- `loop_en`  in  1: wrap to entry 0 after the last entry.
- `sg_strobe`  out  1: to generator `write_strobe`.
- `sg_addr`  out  3: to generator `address`.
- `sg_data`  out  5: to generator `data`.
- `busy`  out  1: high in any state except IDLE.
- `step_idx`  out  IW: entry currently playing.
- `done`  out  1: one-cycle pulse on normal completion.
- `prog_err`  out  1: one-cycle pulse when a `prog_we` is dropped.

## Operation
- **Table:** `DEPTH` entries × {reg word 8b, duration `DUR_W`}.
  - `seq_len` register, 0..`DEPTH`: written from `prog_data` and clamped to `DEPTH`.
  - All entries and `seq_len` reset to 0.
- **Writes:** accepted only in IDLE. In any other state they are dropped and `prog_err` pulses the next cycle. Field 3 is ignored silently.
- **FSM states:** IDLE, SETUP, STROBE, HOLD, WAIT.
  - IDLE → SETUP on `start` && !`stop` && `seq_len` ≠ 0, with `step_idx` = 0. `start` with `seq_len` = 0 is ignored. `start` while busy is ignored.
  - SETUP (1 cycle): `sg_addr`/`sg_data` load from entry `step_idx`; strobe low.
  - STROBE (`STROBE_CYC` cycles): `sg_strobe` = 1; addr/data stable.
  - HOLD (1 cycle): strobe low; addr/data still stable.
  - WAIT: the dwell counter clears on entry and counts `tick` pulses seen while in WAIT. Leave WAIT the cycle after the count reaches the duration. Duration 0 skips WAIT: HOLD goes straight to advance.
  - Advance:
    - If `step_idx` = `seq_len`−1 and !`loop_en`: `done` pulses and the FSM returns to IDLE.
    - If `step_idx` = `seq_len`−1 and `loop_en`: `step_idx` = 0 and the FSM enters SETUP.
    - Otherwise: `step_idx`+1 and the FSM enters SETUP.
- **`stop`:**
  - In SETUP or WAIT: IDLE next cycle; no `done`.
  - In STROBE or HOLD: latched; the write completes, then IDLE after HOLD. A generator write is never truncated.
  - `stop` and `start` together in IDLE: stop wins.
- **Outputs in IDLE:** `sg_addr`/`sg_data` keep their last values; `sg_strobe` = 0.
- **Output registering:** all outputs are registered.
- **Reset values:** every output is 0, the FSM is in IDLE, and the counter is 0. `rst` mid-strobe drops `sg_strobe` on the next edge.

## Timing
- `start` sampled at edge N:
  - SETUP in cycle N+1, addr/data valid.
  - `sg_strobe` high in cycles N+2 … N+1+`STROBE_CYC`.
  - HOLD in cycle N+2+`STROBE_CYC`.
  - WAIT from cycle N+3+`STROBE_CYC`.
- Setup and hold around the strobe are each ≥1 cycle.
- Cycle count per entry is `STROBE_CYC`+2, plus dwell.
- `prog_we` in IDLE: the value is visible to a SETUP starting the following cycle.
- `done` is asserted in the cycle the FSM is back in IDLE, with `busy` = 0.

## Structure
- Package `sg_pkg`:
  - FSM state enum.
  - `prog_field` codes (`FLD_REG`, `FLD_DUR`, `FLD_LEN`).
  - Generator register widths (addr 3, data 5).
- Sub-module `sg_seq_table`: the register file plus `seq_len`, with write-enable and index decode and one async read port.
- FSM and counter live in `sg_sequencer`.

## Test plan
- **Single write:** program entry 0 = 8'hA5 with duration 0, `seq_len` = 1, pulse `start`.
  - `sg_addr` = 5, `sg_data` = 5 in SETUP; strobe high for exactly 2 cycles.
  - `done` at N+5; `busy` falls.
- **Dwell:** entries 0/1 with durations 3/0; tick every 4 cycles.
  - Exactly 3 ticks are counted in WAIT before entry 1's SETUP.
  - A tick coincident with entering WAIT is not counted.
- **Loop:** `seq_len` = 2, `loop_en` = 1, durations 1.
  - `step_idx` sequence is 0,1,0,1…
  - `stop` during WAIT → IDLE next cycle, no `done`.
- **Stop mid-strobe:** assert `stop` in the first STROBE cycle.
  - Strobe still lasts 2 cycles; HOLD occurs; then IDLE.
- **Dropped write and edge cases:**
  - `prog_we` while busy → `prog_err` pulse; the table is unchanged on read-back playback.
  - Length 12 clamps to 8; `start` with length 0 is ignored.
- **Reset:** `rst` asserted in STROBE → all outputs 0 next cycle; the table is cleared.
